// File: rtl/jstk2_spi_master.sv
// SPI mode-0 master for the Pmod JSTK2 joystick; SCLK comes from a clock-enable counter, not a divided clock.
// Optional feature macro JSTK2_LED_EN: adds led_r/led_g/led_b inputs and sends the set-LED command on MOSI.

module jstk2_spi_master #(
  parameter int SCLK_DIV    = 750,
  parameter int FRAME_BYTES = 5,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     MISO,
`ifdef JSTK2_LED_EN
  input  logic [7:0]               led_r,
  input  logic [7:0]               led_g,
  input  logic [7:0]               led_b,
`endif
  output logic                     MOSI,
  output logic                     SS,
  output logic                     SCLK,
  output logic                     busy,
  output logic [8*FRAME_BYTES-1:0] rx_data,
  output logic                     rx_valid,
  output logic [9:0]               x_pos,
  output logic [9:0]               y_pos,
  output logic [2:0]               btn
);

  localparam int          W          = 8 * FRAME_BYTES;
  localparam logic [31:0] DIV_LAST   = 32'(SCLK_DIV - 1);
  localparam logic [31:0] SETUP_LAST = 32'(SS_SETUP - 1);
  localparam logic [31:0] GAP_LAST   = 32'(BYTE_GAP - 1);
  localparam logic [31:0] POLL_LAST  = 32'(POLL_PERIOD - 1);
  localparam logic [15:0] BYTE_LAST  = 16'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

  state_t      state;
  logic [31:0] phase_cnt;
  logic [31:0] poll_cnt;
  logic [2:0]  bit_cnt;
  logic [15:0] byte_cnt;
  logic [W-1:0] rx_sr;
  logic        poll_tick;
  logic        req;

  assign poll_tick = (POLL_PERIOD != 0) && (poll_cnt == POLL_LAST);
  assign req       = start | poll_tick;

`ifdef JSTK2_LED_EN
  logic [W-1:0] tx_sr;
  logic [W-1:0] led_frame;

  assign led_frame = {8'h84, led_r, led_g, led_b, {(W-32){1'b0}}};
`else
  assign MOSI = 1'b0;
`endif

  // Free-running poll timer; wraps on the tick so requests are exactly POLL_PERIOD apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (POLL_PERIOD == 0 || poll_tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      SS        <= 1'b1;
      SCLK      <= 1'b0;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      x_pos     <= '0;
      y_pos     <= '0;
      btn       <= '0;
      rx_sr     <= '0;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
`ifdef JSTK2_LED_EN
      MOSI      <= 1'b0;
      tx_sr     <= '0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state     <= (SS_SETUP > 0) ? SETUP : SHIFT;
            SS        <= 1'b0;
            busy      <= 1'b1;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
`ifdef JSTK2_LED_EN
            MOSI      <= led_frame[W-1];
            tx_sr     <= {led_frame[W-2:0], 1'b0};
`endif
          end
        end

        SETUP: begin
          if (phase_cnt == SETUP_LAST) begin
            state     <= SHIFT;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        // Each bit is a low half then a high half; the falling edge of the last bit closes the byte.
        SHIFT: begin
          if (phase_cnt != DIV_LAST) begin
            phase_cnt <= phase_cnt + 32'd1;
          end else begin
            phase_cnt <= '0;
            if (!SCLK) begin
              SCLK  <= 1'b1;
              rx_sr <= {rx_sr[W-2:0], MISO};
            end else begin
              SCLK    <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && byte_cnt == BYTE_LAST) begin
                state    <= DONE;
                SS       <= 1'b1;
                rx_valid <= 1'b1;
                rx_data  <= rx_sr;
                x_pos    <= {rx_sr[W-15:W-16], rx_sr[W-1:W-8]};
                y_pos    <= {rx_sr[W-31:W-32], rx_sr[W-17:W-24]};
                btn      <= rx_sr[W-38:W-40];
`ifdef JSTK2_LED_EN
                MOSI     <= 1'b0;
`endif
              end else begin
                if (bit_cnt == 3'd7) begin
                  byte_cnt <= byte_cnt + 16'd1;
                  if (BYTE_GAP > 0) begin
                    state <= GAP;
                  end
                end
`ifdef JSTK2_LED_EN
                MOSI  <= tx_sr[W-1];
                tx_sr <= {tx_sr[W-2:0], 1'b0};
`endif
              end
            end
          end
        end

        GAP: begin
          if (phase_cnt == GAP_LAST) begin
            state     <= SHIFT;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jstk2_spi_master.sv
// Bench for jstk2_spi_master: a slow 5-byte instance driven by start, and a fast 6-byte auto-polling instance.
// Both use behavioural joystick slaves; frames and decoded fields are predicted with byte arithmetic.

module tb_jstk2_spi_master;

  localparam int M_DIV = 2, M_FB = 5, M_SETUP = 4, M_GAP = 3;
  localparam int P_DIV = 1, P_FB = 6, P_SETUP = 3, P_GAP = 2, P_POLL = 300;
  localparam int M_W = 8 * M_FB;
  localparam int P_W = 8 * P_FB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic m_rst, m_start, m_miso = 1'b0;
  logic m_mosi, m_ss, m_sclk, m_busy, m_rx_valid;
  logic [M_W-1:0] m_rx_data;
  logic [9:0] m_x, m_y;
  logic [2:0] m_btn;

  logic p_rst, p_start, p_miso = 1'b0;
  logic p_mosi, p_ss, p_sclk, p_busy, p_rx_valid;
  logic [P_W-1:0] p_rx_data;
  logic [9:0] p_x, p_y;
  logic [2:0] p_btn;

`ifdef JSTK2_LED_EN
  logic [7:0] m_led_r = 8'hAA, m_led_g = 8'h55, m_led_b = 8'h0F;
  logic [7:0] p_led_r = 8'h00, p_led_g = 8'h00, p_led_b = 8'h00;
`endif

  logic [63:0] m_exp_mosi, p_exp_mosi;

  jstk2_spi_master #(.SCLK_DIV(M_DIV), .FRAME_BYTES(M_FB), .SS_SETUP(M_SETUP),
                     .BYTE_GAP(M_GAP), .POLL_PERIOD(0)) dut_m (
    .clk(clk), .rst(m_rst), .start(m_start), .MISO(m_miso),
`ifdef JSTK2_LED_EN
    .led_r(m_led_r), .led_g(m_led_g), .led_b(m_led_b),
`endif
    .MOSI(m_mosi), .SS(m_ss), .SCLK(m_sclk), .busy(m_busy), .rx_data(m_rx_data),
    .rx_valid(m_rx_valid), .x_pos(m_x), .y_pos(m_y), .btn(m_btn)
  );

  jstk2_spi_master #(.SCLK_DIV(P_DIV), .FRAME_BYTES(P_FB), .SS_SETUP(P_SETUP),
                     .BYTE_GAP(P_GAP), .POLL_PERIOD(P_POLL)) dut_p (
    .clk(clk), .rst(p_rst), .start(p_start), .MISO(p_miso),
`ifdef JSTK2_LED_EN
    .led_r(p_led_r), .led_g(p_led_g), .led_b(p_led_b),
`endif
    .MOSI(p_mosi), .SS(p_ss), .SCLK(p_sclk), .busy(p_busy), .rx_data(p_rx_data),
    .rx_valid(p_rx_valid), .x_pos(p_x), .y_pos(p_y), .btn(p_btn)
  );

  // Joystick slave for dut_m: shifts on SCLK falls only, records MOSI on rises.
  logic [M_W-1:0] m_frame = '0, m_sh, m_mosi_cap;
  int m_rises = 0, m_low = 0, m_falls = 0, m_valids = 0;

  always @(negedge m_ss) begin
    m_sh = m_frame;
    m_miso = m_sh[M_W-1];
    m_rises = 0;
    m_low = 0;
    m_mosi_cap = '0;
    m_falls++;
  end

  always @(negedge m_sclk) if (!m_ss) begin
    m_sh = {m_sh[M_W-2:0], 1'b0};
    m_miso = m_sh[M_W-1];
  end

  always @(posedge m_sclk) begin
    m_rises++;
    m_mosi_cap = {m_mosi_cap[M_W-2:0], m_mosi};
  end

  always @(negedge clk) begin
    if (!m_ss) m_low++;
    if (m_rx_valid) m_valids++;
  end

  // Joystick slave for dut_p: fresh random bytes each frame, queued as the expected result.
  logic [63:0] p_rnd;
  logic [P_W-1:0] p_sh, p_mosi_cap;
  logic [P_W-1:0] p_exp_q[$];
  int p_rises = 0, p_low = 0, p_falls = 0, p_valids = 0;
  longint p_fall_t = 0, p_prev_t = 0;

  always @(negedge p_ss) begin
    p_rnd = {$urandom, $urandom};
    p_sh = p_rnd[P_W-1:0];
    p_exp_q.push_back(p_sh);
    p_miso = p_sh[P_W-1];
    p_rises = 0;
    p_low = 0;
    p_mosi_cap = '0;
    p_prev_t = p_fall_t;
    p_fall_t = longint'($time);
    p_falls++;
  end

  always @(negedge p_sclk) if (!p_ss) begin
    p_sh = {p_sh[P_W-2:0], 1'b0};
    p_miso = p_sh[P_W-1];
  end

  always @(posedge p_sclk) begin
    p_rises++;
    p_mosi_cap = {p_mosi_cap[P_W-2:0], p_mosi};
  end

  always @(negedge clk) begin
    if (!p_ss) p_low++;
    if (p_rx_valid) p_valids++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int byteOf(input logic [63:0] f, input int fb, input int k);
    logic [63:0] s;
    s = f >> (8 * (fb - 1 - k));
    return int'(s & 64'hFF);
  endfunction

  function automatic logic [63:0] randFrame();
    return {$urandom, $urandom};
  endfunction

  task automatic checkFields(input string tag, input int fb, input logic [63:0] f,
                             input logic [63:0] rx, input logic [9:0] x, input logic [9:0] y,
                             input logic [2:0] b, input int low, input int exp_low,
                             input int rises, input logic [63:0] mcap, input logic [63:0] emosi);
    checkOutput({tag, "_rx_data"}, rx, f);
    checkOutput({tag, "_x"}, 64'(x), 64'(byteOf(f, fb, 1) % 4 * 256 + byteOf(f, fb, 0)));
    checkOutput({tag, "_y"}, 64'(y), 64'(byteOf(f, fb, 3) % 4 * 256 + byteOf(f, fb, 2)));
    checkOutput({tag, "_btn"}, 64'(b), 64'(byteOf(f, fb, 4) % 8));
    checkOutput({tag, "_ss_low"}, 64'(low), 64'(exp_low));
    checkOutput({tag, "_rises"}, 64'(rises), 64'(8 * fb));
    checkOutput({tag, "_mosi"}, mcap, emosi);
  endtask

  task automatic waitValid(input bit use_p, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 3000) begin
      @(negedge clk);
      n++;
      if (use_p ? p_rx_valid : m_rx_valid) ok = 1'b1;
    end
  endtask

  // Raise start for 'hold' cycles, optionally pulse it again 'second_at' cycles after the first rise.
  task automatic applyStimulus(input int hold, input int second_at);
    @(negedge clk);
    m_start = 1'b1;
    repeat (hold) @(negedge clk);
    m_start = 1'b0;
    if (second_at > hold) begin
      repeat (second_at - hold) @(negedge clk);
      m_start = 1'b1;
      @(negedge clk);
      m_start = 1'b0;
    end
  endtask

  task automatic checkRxM(input logic [M_W-1:0] data, input string tag);
    bit ok;
    waitValid(1'b0, ok);
    checkOutput({tag, "_seen"}, 64'(ok), 64'd1);
    if (ok) begin
      checkFields(tag, M_FB, 64'(data), 64'(m_rx_data), m_x, m_y, m_btn, m_low,
                  M_SETUP + M_FB * 16 * M_DIV + (M_FB - 1) * M_GAP, m_rises,
                  64'(m_mosi_cap), m_exp_mosi);
      checkOutput({tag, "_ss_done"}, 64'(m_ss), 64'd1);
      checkOutput({tag, "_busy_done"}, 64'(m_busy), 64'd1);
      @(negedge clk);
      checkOutput({tag, "_valid_1cyc"}, 64'(m_rx_valid), 64'd0);
      checkOutput({tag, "_busy_after"}, 64'(m_busy), 64'd0);
    end
  endtask

  task automatic checkRxP(input string tag, input bit check_period);
    bit ok;
    logic [P_W-1:0] f;
    waitValid(1'b1, ok);
    checkOutput({tag, "_seen"}, 64'(ok), 64'd1);
    checkOutput({tag, "_queued"}, 64'(p_exp_q.size() > 0), 64'd1);
    if (ok && p_exp_q.size() > 0) begin
      f = p_exp_q.pop_front();
      checkFields(tag, P_FB, 64'(f), 64'(p_rx_data), p_x, p_y, p_btn, p_low,
                  P_SETUP + P_FB * 16 * P_DIV + (P_FB - 1) * P_GAP, p_rises,
                  64'(p_mosi_cap), p_exp_mosi);
      if (check_period) checkOutput({tag, "_period"}, 64'((p_fall_t - p_prev_t) / 10), 64'(P_POLL));
      @(negedge clk);
      checkOutput({tag, "_valid_1cyc"}, 64'(p_rx_valid), 64'd0);
      checkOutput({tag, "_busy_between"}, 64'(p_busy), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] d;
    int f0, v0;
    m_rst = 1'b0;
    p_rst = 1'b0;
    m_start = 1'b0;
    p_start = 1'b0;
`ifdef JSTK2_LED_EN
    p_led_r = 8'($urandom);
    p_led_g = 8'($urandom);
    p_led_b = 8'($urandom);
    m_exp_mosi = {32'h0, 8'h84, m_led_r, m_led_g, m_led_b} << (8 * (M_FB - 4));
    p_exp_mosi = {32'h0, 8'h84, p_led_r, p_led_g, p_led_b} << (8 * (P_FB - 4));
`else
    m_exp_mosi = '0;
    p_exp_mosi = '0;
`endif
    #1;
    m_rst = 1'b1;
    p_rst = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_ss", 64'(m_ss), 64'd1);
    checkOutput("rst_sclk", 64'(m_sclk), 64'd0);
    checkOutput("rst_mosi", 64'(m_mosi), 64'd0);
    checkOutput("rst_busy", 64'(m_busy), 64'd0);
    checkOutput("rst_valid", 64'(m_rx_valid), 64'd0);
    checkOutput("rst_rx_data", 64'(m_rx_data), 64'd0);
    checkOutput("rst_xyb", {m_x, m_y, m_btn}, 64'd0);
    checkOutput("rst_p_ss", 64'(p_ss), 64'd1);
    m_rst = 1'b0;

    m_frame = 40'h2C01000305;
    applyStimulus(1, 0);
    checkRxM(40'h2C01000305, "decode");
    checkOutput("decode_x300", 64'(m_x), 64'd300);
    checkOutput("decode_y768", 64'(m_y), 64'd768);
    checkOutput("decode_btn5", 64'(m_btn), 64'd5);
    checkOutput("decode_low176", 64'(m_low), 64'd176);

    for (int i = 0; i < 4; i++) begin
      d = randFrame();
      m_frame = d[M_W-1:0];
      repeat (3) @(negedge clk);
      applyStimulus(1, 0);
      checkRxM(d[M_W-1:0], $sformatf("rand%0d", i));
    end

    f0 = m_falls;
    v0 = m_valids;
    d = randFrame();
    m_frame = d[M_W-1:0];
    applyStimulus(10, 50);
    checkRxM(d[M_W-1:0], "drop");
    repeat (300) @(negedge clk);
    checkOutput("drop_frames", 64'(m_falls - f0), 64'd1);
    checkOutput("drop_valids", 64'(m_valids - v0), 64'd1);
    checkOutput("drop_idle", 64'(m_busy), 64'd0);

    d = randFrame();
    m_frame = d[M_W-1:0];
    applyStimulus(1, 0);
    repeat (99) @(negedge clk);
    checkOutput("rstmid_inframe", 64'(m_ss), 64'd0);
    #2;
    m_rst = 1'b1;
    #1;
    checkOutput("rstmid_ss", 64'(m_ss), 64'd1);
    checkOutput("rstmid_sclk", 64'(m_sclk), 64'd0);
    checkOutput("rstmid_busy", 64'(m_busy), 64'd0);
    checkOutput("rstmid_rx_data", 64'(m_rx_data), 64'd0);
    checkOutput("rstmid_xyb", {m_x, m_y, m_btn}, 64'd0);
    v0 = m_valids;
    repeat (3) @(negedge clk);
    m_rst = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("rstmid_no_valid", 64'(m_valids - v0), 64'd0);
    checkOutput("rstmid_idle_ss", 64'(m_ss), 64'd1);
    d = randFrame();
    m_frame = d[M_W-1:0];
    applyStimulus(1, 0);
    checkRxM(d[M_W-1:0], "after_rst");

    @(negedge clk);
    p_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkRxP($sformatf("poll%0d", k), k > 0);
    end
    repeat (2) @(negedge clk);
    checkOutput("poll_valid_per_frame", 64'(p_valids), 64'(p_falls));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
